// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and defaults for the mul/div unit
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 6;

  typedef logic [1:0] md_op_t;

  localparam md_op_t MD_MULT  = 2'b00;
  localparam md_op_t MD_MULTU = 2'b01;
  localparam md_op_t MD_DIV   = 2'b10;
  localparam md_op_t MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic md_is_div(md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - execute-stage request/response bundle for the mul/div unit
interface muldiv_if import muldiv_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
) ();

  logic             flush;
  logic             Start_EX;
  md_op_t           Op_EX;
  logic [WIDTH-1:0] SrcA_EX;
  logic [WIDTH-1:0] SrcB_EX;
  logic             Rd_EX;
  logic             Mt_EX;
  logic             HiSel_EX;
  logic [WIDTH-1:0] RdData_MD;
  logic             Busy_MD;
  logic             Stall_MD;
  logic             Done_MD;

  modport master (
    output flush, Start_EX, Op_EX, SrcA_EX, SrcB_EX, Rd_EX, Mt_EX, HiSel_EX,
    input  RdData_MD, Busy_MD, Stall_MD, Done_MD
  );

  modport slave (
    input  flush, Start_EX, Op_EX, SrcA_EX, SrcB_EX, Rd_EX, Mt_EX, HiSel_EX,
    output RdData_MD, Busy_MD, Stall_MD, Done_MD
  );

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: MSB-first shift-add or restoring divide step
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               op_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               bit_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   diff;
  logic               borrow;
  logic [2*WIDTH-1:0] div_acc;

  always_comb begin
    mul_acc = {acc_i[2*WIDTH-2:0], 1'b0} + (bit_i ? {{WIDTH{1'b0}}, a_i} : '0);
    // Remainder lives in the upper half, quotient bits shift into the lower half.
    rem_sh  = {acc_i[2*WIDTH-1:WIDTH], bit_i};
    borrow  = rem_sh < {1'b0, b_i};
    diff    = rem_sh[WIDTH-1:0] - b_i;
    div_acc = {(borrow ? rem_sh[WIDTH-1:0] : diff), acc_i[WIDTH-2:0], ~borrow};
    acc_o   = op_div_i ? div_acc : mul_acc;
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/DIV unit owning HI/LO; MULDIV_EARLY_EXIT_EN skips zero operands
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave md
);

  localparam int IDX_W = $clog2(WIDTH);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, a_raw_q, a_raw_d;
  logic               sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  md_op_t             op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [IDX_W-1:0]   idx;
  logic               step_bit;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic               in_signed;

  assign idx      = cnt_q[IDX_W-1:0];
  assign step_bit = md_is_div(op_q) ? a_q[idx] : b_q[idx];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_div_i (md_is_div(op_q)),
    .acc_i    (acc_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .bit_i    (step_bit),
    .acc_o    (step_acc)
  );

  // Sign fixup: the datapath only ever sees magnitudes.
  always_comb begin
    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    if (md_is_div(op_q)) begin
      if (bz_q) begin
        fix_hi = a_raw_q;
        fix_lo = '1;
      end else begin
        fix_hi = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        fix_lo = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end
    end else begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end
  end

  assign in_signed = md_is_signed(md.Op_EX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    a_raw_d = a_raw_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (md.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (md.Start_EX) begin
            sa_d    = in_signed & md.SrcA_EX[WIDTH-1];
            sb_d    = in_signed & md.SrcB_EX[WIDTH-1];
            a_d     = (in_signed & md.SrcA_EX[WIDTH-1]) ? -md.SrcA_EX : md.SrcA_EX;
            b_d     = (in_signed & md.SrcB_EX[WIDTH-1]) ? -md.SrcB_EX : md.SrcB_EX;
            a_raw_d = md.SrcA_EX;
            bz_d    = (md.SrcB_EX == '0);
            op_d    = md.Op_EX;
            cnt_d   = CNT_W'(WIDTH - 1);
            acc_d   = '0;
`ifdef MULDIV_EARLY_EXIT_EN
            state_d = ((md.SrcA_EX == '0) || (md.SrcB_EX == '0)) ? FIX : RUN;
`else
            state_d = RUN;
`endif
          end else if (md.Mt_EX) begin
            if (md.HiSel_EX) hi_d = md.SrcA_EX;
            else             lo_d = md.SrcA_EX;
          end
        end
        RUN: begin
          acc_d = step_acc;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_d = FIX;
        end
        FIX: begin
          hi_d    = fix_hi;
          lo_d    = fix_lo;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      a_raw_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      op_q    <= MD_MULT;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_raw_q <= a_raw_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.RdData_MD = md.HiSel_EX ? hi_q : lo_q;
  assign md.Busy_MD   = (state_q != IDLE);
  assign md.Stall_MD  = md.Busy_MD & (md.Start_EX | md.Rd_EX | md.Mt_EX);
  assign md.Done_MD   = (state_q == FIX) & ~md.flush;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide responder for the execute stage. It services the MULT/MULTU/DIV/DIVU, MFHI/MFLO and MTHI/MTLO requests that execute forwards, owns the HI/LO architectural registers, and drives the stall that execute ORs into Stall_EX.
- Radix-2: one bit per cycle, with a sign-fixup cycle. Sits beside the ALU in the EX stage.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; aborts any operation in flight.
- Start_EX  in  1  request a new mul/div this cycle.
- Op_EX  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- SrcA_EX  in  WIDTH  multiplicand / dividend.
- SrcB_EX  in  WIDTH  multiplier / divisor.
- Rd_EX  in  1  MFHI/MFLO request.
- Mt_EX  in  1  MTHI/MTLO request; data comes from SrcA_EX.
- HiSel_EX  in  1  1 selects HI, 0 selects LO, for Rd_EX and Mt_EX.
- RdData_MD  out  WIDTH  HiSel_EX ? HI : LO; combinational from the registers.
- Busy_MD  out  1  an operation is in flight.
- Stall_MD  out  1  stall request to execute.
- Done_MD  out  1  one-cycle pulse; HI/LO updated this edge.

Behaviour:
- Reset (async, rst_n=0): state IDLE; HI=0, LO=0, counter=0; Busy_MD=0, Stall_MD=0, Done_MD=0.
- States: IDLE, RUN, FIX.
  - IDLE→RUN when Start_EX=1 and flush=0. On that edge:
    - latch operand magnitudes (|x| for signed ops, raw for unsigned ops), both operand signs and Op;
    - counter=WIDTH-1; clear the 2*WIDTH working accumulator.
  - RUN, every cycle, counter decrements:
    - multiply: shift-add one multiplier bit into the 2*WIDTH partial product;
    - divide: restoring step (shift remainder, trial-subtract divisor, set quotient bit when no borrow).
  - RUN→FIX when counter==0.
  - FIX: sign fixup, then write HI/LO; Done_MD=1; →IDLE.
- Latency: Start accepted at edge N; Busy_MD high for cycles N+1..N+WIDTH+1; Done_MD in cycle N+WIDTH+1. The new HI/LO is visible on RdData_MD from cycle N+WIDTH+2, i.e. 34 cycles after start for WIDTH=32.
- Multiply result:
  - {HI,LO} = 2*WIDTH product.
  - Signed: negate the 64-bit product when operand signs differ.
  - Magnitude of -2^31 is 0x80000000 unsigned, so no overflow case exists.
- Divide result:
  - LO = quotient, HI = remainder.
  - Signed: quotient negated when signs differ; remainder takes the dividend's sign.
  - -2^31 / -1: LO=0x80000000, HI=0.
- Divide by zero (either signedness): LO=all ones, HI=SrcA as latched (raw, not magnitude). Full latency.
- Stall_MD = Busy_MD & (Start_EX | Rd_EX | Mt_EX).
  - A Start, Rd or Mt presented while busy is held off, not dropped.
  - Execute keeps the request stable while stalled.
- Mt_EX in IDLE writes SrcA_EX into the selected register at the edge. Mt_EX and Start_EX together in IDLE: Start wins, Mt is ignored. Decode never issues both.
- Rd_EX in IDLE: RdData_MD is valid the same cycle, with no stall.
- Start_EX while busy: ignored (stalled); accepted the cycle after Done_MD.
- flush=1: any state→IDLE next edge. HI/LO keep their pre-operation values, no Done_MD pulse, Busy_MD drops the next cycle.
  - flush with Start_EX in IDLE: start not accepted.
  - flush has priority over every other event.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.

Optional Feature:
- Macro MULDIV_EARLY_EXIT_EN.
- Defined: at IDLE→RUN, if SrcB_EX==0 or SrcA_EX==0, the FSM goes straight to FIX.
  - Done_MD comes at N+1 and the result is visible at N+2.
  - Results: multiply HI=LO=0; divide by zero as specified above; dividend 0 gives HI=LO=0.
- Undefined: every operation takes the full WIDTH+1 busy cycles; result values are identical.

Decomposition:
- Shared package (muldiv_pkg):
  - Op encodings MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11;
  - state enum IDLE/RUN/FIX;
  - WIDTH default.
- Execute maps AluControl codes onto these constants.
- One sub-module: muldiv_step, the combinational single-iteration datapath (shift-add or restoring subtract, selected by an op-is-div bit). The parent module holds the FSM, counter, sign fixup and HI/LO.

Test Plan:
- Reset low mid-RUN → next cycle HI=0, LO=0, Busy_MD=0; a subsequent MULTU 3×5 gives HI=0, LO=15, Done_MD 33 cycles after start.
- MULT 0xFFFFFFFF(-1) × 0x00000002 → HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU on the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV -7 / 2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 7/2 → LO=3, HI=1. DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- Start a MULT, then hold Rd_EX=1 at cycle N+5 → Stall_MD=1 until Done_MD; Stall_MD=0 the cycle after, with the new value on RdData_MD. MTLO 0x1234 in IDLE → LO=0x1234, no stall.
- Pre-load HI=0xAAAA, LO=0x5555; start DIV 100/7, flush at N+10 → Busy_MD=0 next cycle, no Done_MD, HI/LO still 0xAAAA/0x5555.
- DIVU 9/0 → LO=0xFFFFFFFF, HI=9. Done_MD at N+WIDTH+1 without MULDIV_EARLY_EXIT_EN; at N+1 with it defined.
